// File: rtl/key_pkg.sv
// Shared definitions for the multi-key debouncer: channel FSM encodings
// and the millisecond tick derivation.
package key_pkg;

  typedef enum logic [1:0] {
    ST_RELEASED = 2'd0,
    ST_PRESSED  = 2'd1,
    ST_LONG     = 2'd2
  } key_state_e;

  function automatic int tick_cycles(input int clk_hz);
    return clk_hz / 1000;
  endfunction

endpackage

// File: rtl/key_chan.sv
// One key channel: synchroniser, tick-based debounce, press/long/repeat FSM,
// toggle and event counter. Held at reset values while en is low.
module key_chan
  import key_pkg::*;
#(
  parameter int DEBOUNCE_MS = 20,
  parameter int LONG_MS     = 1000,
  parameter int REPEAT_MS   = 200,
  parameter int CNT_W       = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick,
  input  logic             en,
  input  logic             key_raw,
  output logic             key_level,
  output logic             key_press,
  output logic             key_release,
  output logic             key_long,
  output logic             key_repeat,
  output logic             key_toggle,
  output logic [CNT_W-1:0] key_count,
  output logic [1:0]       state_dbg
);

  localparam int DW = $clog2(DEBOUNCE_MS + 1);
  localparam int HW = $clog2(LONG_MS + 1);
  localparam int RW = $clog2(REPEAT_MS + 1);

  logic             sync1_q, sync1_d, sync2_q, sync2_d;
  logic [DW-1:0]    db_cnt_q, db_cnt_d;
  logic [HW-1:0]    hold_cnt_q, hold_cnt_d;
  logic [RW-1:0]    rep_cnt_q, rep_cnt_d;
  logic             level_q, level_d;
  logic             press_q, press_d, release_q, release_d;
  logic             long_q, long_d, repeat_q, repeat_d;
  logic             toggle_q, toggle_d;
  logic [CNT_W-1:0] count_q, count_d;
  key_state_e       state_q, state_d;

  always_comb begin
    sync1_d    = key_raw;
    sync2_d    = sync1_q;
    db_cnt_d   = db_cnt_q;
    hold_cnt_d = hold_cnt_q;
    rep_cnt_d  = rep_cnt_q;
    level_d    = level_q;
    state_d    = state_q;
    toggle_d   = toggle_q;
    count_d    = count_q;
    press_d    = 1'b0;
    release_d  = 1'b0;
    long_d     = 1'b0;
    repeat_d   = 1'b0;
    if (!en) begin
      level_d    = 1'b0;
      db_cnt_d   = '0;
      hold_cnt_d = '0;
      rep_cnt_d  = '0;
      state_d    = ST_RELEASED;
      toggle_d   = 1'b0;
      count_d    = '0;
    end else begin
      // Keys are active-low; compare the pressed sense against the accepted level.
      if (~sync2_q == level_q) begin
        db_cnt_d = '0;
      end else if (tick) begin
        if (db_cnt_q == DW'(DEBOUNCE_MS - 1)) begin
          level_d  = ~level_q;
          db_cnt_d = '0;
        end else begin
          db_cnt_d = db_cnt_q + 1'b1;
        end
      end
      case (state_q)
        ST_RELEASED: begin
          if (level_d && !level_q) begin
            state_d    = ST_PRESSED;
            press_d    = 1'b1;
            toggle_d   = ~toggle_q;
            count_d    = count_q + 1'b1;
            hold_cnt_d = '0;
            rep_cnt_d  = '0;
          end
        end
        ST_PRESSED: begin
          if (!level_d) begin
            state_d    = ST_RELEASED;
            release_d  = 1'b1;
            hold_cnt_d = '0;
            rep_cnt_d  = '0;
          end else if (tick) begin
            if (hold_cnt_q == HW'(LONG_MS - 1)) begin
              state_d   = ST_LONG;
              long_d    = 1'b1;
              rep_cnt_d = '0;
            end else begin
              hold_cnt_d = hold_cnt_q + 1'b1;
            end
          end
        end
        ST_LONG: begin
          if (!level_d) begin
            state_d    = ST_RELEASED;
            release_d  = 1'b1;
            hold_cnt_d = '0;
            rep_cnt_d  = '0;
          end else if (tick) begin
            if (rep_cnt_q == RW'(REPEAT_MS - 1)) begin
              repeat_d  = 1'b1;
              count_d   = count_q + 1'b1;
              rep_cnt_d = '0;
            end else begin
              rep_cnt_d = rep_cnt_q + 1'b1;
            end
          end
        end
        default: state_d = ST_RELEASED;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q    <= 1'b1;
      sync2_q    <= 1'b1;
      db_cnt_q   <= '0;
      hold_cnt_q <= '0;
      rep_cnt_q  <= '0;
      level_q    <= 1'b0;
      state_q    <= ST_RELEASED;
      toggle_q   <= 1'b0;
      count_q    <= '0;
      press_q    <= 1'b0;
      release_q  <= 1'b0;
      long_q     <= 1'b0;
      repeat_q   <= 1'b0;
    end else begin
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      db_cnt_q   <= db_cnt_d;
      hold_cnt_q <= hold_cnt_d;
      rep_cnt_q  <= rep_cnt_d;
      level_q    <= level_d;
      state_q    <= state_d;
      toggle_q   <= toggle_d;
      count_q    <= count_d;
      press_q    <= press_d;
      release_q  <= release_d;
      long_q     <= long_d;
      repeat_q   <= repeat_d;
    end
  end

  assign key_level   = level_q;
  assign key_press   = press_q;
  assign key_release = release_q;
  assign key_long    = long_q;
  assign key_repeat  = repeat_q;
  assign key_toggle  = toggle_q;
  assign key_count   = count_q;
  assign state_dbg   = state_q;

endmodule

// File: rtl/key_debounce_multi.sv
// Multi-key debouncer top: shared 1 ms tick, power-up hold-off and one
// key_chan per key. dbg_state exposes each channel FSM (2 bits per key).
module key_debounce_multi
  import key_pkg::*;
#(
  parameter int NUM_KEYS    = 4,
  parameter int CLK_HZ      = 50_000_000,
  parameter int HOLDOFF_MS  = 1000,
  parameter int DEBOUNCE_MS = 20,
  parameter int LONG_MS     = 1000,
  parameter int REPEAT_MS   = 200,
  parameter int CNT_W       = 3
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_KEYS-1:0]       key_in,
  output logic                      ready,
  output logic [NUM_KEYS-1:0]       key_level,
  output logic [NUM_KEYS-1:0]       key_press,
  output logic [NUM_KEYS-1:0]       key_release,
  output logic [NUM_KEYS-1:0]       key_long,
  output logic [NUM_KEYS-1:0]       key_repeat,
  output logic [NUM_KEYS-1:0]       key_toggle,
  output logic [NUM_KEYS*CNT_W-1:0] key_count,
  output logic [NUM_KEYS*2-1:0]     dbg_state
);

  localparam int TICK_CYC = tick_cycles(CLK_HZ);
  localparam int TW       = $clog2(TICK_CYC + 1);
  localparam int OW       = $clog2(HOLDOFF_MS + 1);

  logic [TW-1:0] tick_cnt_q, tick_cnt_d;
  logic [OW-1:0] hold_cnt_q, hold_cnt_d;
  logic          ready_q, ready_d;
  logic          tick;

  always_comb begin
    tick       = (tick_cnt_q == TW'(TICK_CYC - 1));
    tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;
    hold_cnt_d = hold_cnt_q;
    ready_d    = ready_q;
    // Hold-off counts whole ticks; ready rises on the HOLDOFF_MS-th one.
    if (!ready_q && tick) begin
      if (hold_cnt_q == OW'(HOLDOFF_MS - 1)) ready_d = 1'b1;
      else hold_cnt_d = hold_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tick_cnt_q <= '0;
      hold_cnt_q <= '0;
      ready_q    <= 1'b0;
    end else begin
      tick_cnt_q <= tick_cnt_d;
      hold_cnt_q <= hold_cnt_d;
      ready_q    <= ready_d;
    end
  end

  assign ready = ready_q;

  for (genvar k = 0; k < NUM_KEYS; k++) begin : g_chan
    key_chan #(
      .DEBOUNCE_MS (DEBOUNCE_MS),
      .LONG_MS     (LONG_MS),
      .REPEAT_MS   (REPEAT_MS),
      .CNT_W       (CNT_W)
    ) u_chan (
      .clk         (clk),
      .rst         (rst),
      .tick        (tick),
      .en          (ready_q),
      .key_raw     (key_in[k]),
      .key_level   (key_level[k]),
      .key_press   (key_press[k]),
      .key_release (key_release[k]),
      .key_long    (key_long[k]),
      .key_repeat  (key_repeat[k]),
      .key_toggle  (key_toggle[k]),
      .key_count   (key_count[k*CNT_W +: CNT_W]),
      .state_dbg   (dbg_state[k*2 +: 2])
    );
  end

endmodule
